score_keeper: RTL and testbench

//  Sits directly downstream of the game state FSM. Consumes its screen flags
//  (Game1Screen/Game2Screen, MainS/StartScreen) plus the hit_target/hit_floor

---
 rtl/score_keeper.sv | 135 +++++++++++++
 tb/tb_score_keeper.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Per-round score keeper for the paddle game: binary and BCD score, lives,
// game-over flag and a session high score, all registered on the frame clock.
module score_keeper #(
  parameter int unsigned MAX_SCORE = 99,
  parameter int unsigned LIVES     = 3
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        game_active,
  input  logic        clear,
  input  logic        hit_target,
  input  logic        hit_floor,
  output logic [10:0] Score,
  output logic [3:0]  hextotal,
  output logic [3:0]  hextotal2,
  output logic [3:0]  lives,
  output logic        game_over,
  output logic [10:0] high_score
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  localparam logic [10:0] MaxScore  = 11'(MAX_SCORE);
  localparam logic [3:0]  LivesInit = 4'(LIVES);

  logic [1:0]  state_q, state_d;
  logic [10:0] score_q, score_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  lives_q, lives_d;
  logic        over_q, over_d;
  logic [10:0] high_q, high_d;
  logic        hitPrev_q, floorPrev_q;

  logic hitEvt;
  logic floorEvt;
  logic canInc;

  // Collision strobes are levels; only their rising edges count.
  assign hitEvt   = hit_target & ~hitPrev_q;
  assign floorEvt = hit_floor & ~floorPrev_q;
  assign canInc   = hitEvt && (score_q < MaxScore);

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    lives_d = lives_q;
    over_d  = over_q;
    high_d  = high_q;

    if (clear) begin
      state_d = ST_IDLE;
      score_d = 11'd0;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      lives_d = LivesInit;
      over_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (game_active) state_d = ST_PLAY;
        end
        ST_PLAY: begin
          if (!game_active) begin
            state_d = ST_PAUSED;
          end else begin
            if (canInc) begin
              score_d = score_q + 11'd1;
              if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
              end else begin
                ones_d = ones_q + 4'd1;
              end
            end
            // A same-frame hit is already folded into score_d before the round ends.
            if (floorEvt) begin
              if (lives_q <= 4'd1) begin
                lives_d = 4'd0;
                state_d = ST_OVER;
                over_d  = 1'b1;
                if (score_d > high_q) high_d = score_d;
              end else begin
                lives_d = lives_q - 4'd1;
              end
            end
          end
        end
        ST_PAUSED: begin
          if (game_active) state_d = ST_PLAY;
        end
        default: begin
          state_d = ST_OVER;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      score_q     <= 11'd0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
      lives_q     <= LivesInit;
      over_q      <= 1'b0;
      high_q      <= 11'd0;
      hitPrev_q   <= 1'b0;
      floorPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      lives_q     <= lives_d;
      over_q      <= over_d;
      high_q      <= high_d;
      hitPrev_q   <= hit_target;
      floorPrev_q <= hit_floor;
    end
  end

  assign Score      = score_q;
  assign hextotal   = ones_q;
  assign hextotal2  = tens_q;
  assign lives      = lives_q;
  assign game_over  = over_q;
  assign high_score = high_q;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: directed frames push expected snapshots,
// a negedge monitor pops and compares them against the registered outputs.
module tb_score_keeper;

  logic        frame_clk;
  logic        Reset_n;
  logic        game_active;
  logic        clear;
  logic        hit_target;
  logic        hit_floor;
  logic [10:0] Score;
  logic [3:0]  hextotal;
  logic [3:0]  hextotal2;
  logic [3:0]  lives;
  logic        game_over;
  logic [10:0] high_score;

  typedef struct {
    string name;
    int    score;
    int    ones;
    int    tens;
    int    lives;
    int    over;
    int    high;
  } exp_t;

  exp_t sb[$];
  int   cmpCount  = 0;
  int   failCount = 0;

  score_keeper #(.MAX_SCORE(99), .LIVES(3)) dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .game_active(game_active),
    .clear      (clear),
    .hit_target (hit_target),
    .hit_floor  (hit_floor),
    .Score      (Score),
    .hextotal   (hextotal),
    .hextotal2  (hextotal2),
    .lives      (lives),
    .game_over  (game_over),
    .high_score (high_score)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic compareField(input string name, input string field, input int act, input int req);
    cmpCount++;
    if (act != req) begin
      failCount++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
    end
  endtask

  // Outputs only change on posedge, so negedge sampling sees settled values.
  always @(negedge frame_clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      compareField(e.name, "Score",      int'(Score),      e.score);
      compareField(e.name, "hextotal",   int'(hextotal),   e.ones);
      compareField(e.name, "hextotal2",  int'(hextotal2),  e.tens);
      compareField(e.name, "lives",      int'(lives),      e.lives);
      compareField(e.name, "game_over",  int'(game_over),  e.over);
      compareField(e.name, "high_score", int'(high_score), e.high);
    end
  end

  task automatic applyStimulus(input logic rstN, input logic clr, input logic act,
                               input logic hit, input logic flr);
    @(negedge frame_clk);
    Reset_n     = rstN;
    clear       = clr;
    game_active = act;
    hit_target  = hit;
    hit_floor   = flr;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int score, input int lv,
                             input int over, input int high);
    exp_t e;
    e.name  = name;
    e.score = score;
    e.ones  = score % 10;
    e.tens  = score / 10;
    e.lives = lv;
    e.over  = over;
    e.high  = high;
    sb.push_back(e);
  endtask

  // One hit pulse in PLAY: rising frame then a low frame.
  task automatic hitPulse();
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset_n = 0; clear = 0; game_active = 0; hit_target = 0; hit_floor = 0;

    // Reset held for two frames
    applyStimulus(0, 0, 0, 0, 0); checkOutput("reset1", 0, 3, 0, 0);
    applyStimulus(0, 0, 1, 1, 1); checkOutput("reset2", 0, 3, 0, 0);

    // New round: clear, then go active
    applyStimulus(1, 1, 0, 0, 0); checkOutput("clear", 0, 3, 0, 0);
    applyStimulus(1, 0, 1, 0, 0); checkOutput("enterPlay", 0, 3, 0, 0);

    // Twelve hits, each held high for five frames
    for (int i = 1; i <= 12; i++) begin
      for (int k = 0; k < 5; k++) applyStimulus(1, 0, 1, 1, 0);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput($sformatf("hold12_%0d", i), i, 3, 0, 0);
    end

    // Pause with events in the same frame, strobes held through resume
    applyStimulus(1, 0, 0, 1, 1); checkOutput("pauseEdge", 12, 3, 0, 0);
    applyStimulus(1, 0, 0, 1, 0); checkOutput("pausedHeld", 12, 3, 0, 0);
    applyStimulus(1, 0, 1, 1, 0); checkOutput("resume", 12, 3, 0, 0);
    applyStimulus(1, 0, 1, 1, 0); checkOutput("resumedHeld", 12, 3, 0, 0);
    applyStimulus(1, 0, 1, 0, 0); checkOutput("released", 12, 3, 0, 0);

    // Climb to 98, then saturate at 99
    for (int i = 13; i <= 98; i++) hitPulse();
    checkOutput("at98", 98, 3, 0, 0);
    hitPulse(); checkOutput("sat99a", 99, 3, 0, 0);
    hitPulse(); checkOutput("sat99b", 99, 3, 0, 0);
    hitPulse(); checkOutput("sat99c", 99, 3, 0, 0);

    // Clear mid-play does not record a high score
    applyStimulus(1, 1, 1, 0, 0); checkOutput("clearMidPlay", 0, 3, 0, 0);
    applyStimulus(1, 0, 1, 0, 0); checkOutput("replay", 0, 3, 0, 0);
    for (int i = 1; i <= 7; i++) hitPulse();
    checkOutput("score7", 7, 3, 0, 0);
    applyStimulus(1, 0, 1, 0, 1); checkOutput("lose1", 7, 2, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 1); checkOutput("lose2", 7, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);

    // Last life lost together with a hit: hit counts first
    applyStimulus(1, 0, 1, 1, 1); checkOutput("lastLife", 8, 0, 1, 8);
    applyStimulus(1, 0, 1, 0, 0); checkOutput("overIdle", 8, 0, 1, 8);
    applyStimulus(1, 0, 1, 1, 1); checkOutput("overHit", 8, 0, 1, 8);
    applyStimulus(1, 0, 0, 0, 0); checkOutput("overInactive", 8, 0, 1, 8);

    // Clear out of OVER keeps the high score
    applyStimulus(1, 1, 0, 0, 0); checkOutput("clearOver", 0, 3, 0, 8);
    applyStimulus(1, 0, 1, 0, 0); checkOutput("round3", 0, 3, 0, 8);
    hitPulse(); checkOutput("round3hit", 1, 3, 0, 8);

    // Lower finishing score leaves the high score alone
    for (int i = 2; i >= 0; i--) begin
      applyStimulus(1, 0, 1, 0, 1);
      checkOutput($sformatf("floor_%0d", i), 1, i, (i == 0) ? 1 : 0, 8);
      applyStimulus(1, 0, 1, 0, 0);
    end

    // Reset wipes everything, including the high score
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    hitPulse(); checkOutput("preReset", 1, 3, 0, 8);
    applyStimulus(0, 0, 1, 1, 1); checkOutput("midPlayReset", 0, 3, 0, 0);
    applyStimulus(1, 0, 1, 1, 0); checkOutput("afterResetIdle", 0, 3, 0, 0);
    applyStimulus(1, 0, 1, 1, 0); checkOutput("afterResetHeld", 0, 3, 0, 0);

    @(negedge frame_clk);
    @(negedge frame_clk);
    cmpCount++;
    if (sb.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
